// File: rtl/ddr_ctr_rd_resp.sv
// Read-response side of a DDR controller model: waits out an init delay, then serves
// one INCR read burst at a time with synthetic data and SLVERR above the address limit.
//
// state | meaning
// INIT  | post-reset settle delay, ddr_ready low
// IDLE  | arready high, waiting for a read address
// WAIT  | read latency countdown, rvalid low
// BURST | presenting beats until the rlast handshake
module ddr_ctr_rd_resp #(
    parameter int          INIT_CYCLES = 16,
    parameter int          RD_LATENCY  = 4,
    parameter logic [31:0] ADDR_LIMIT  = 32'h0001_0000,
    parameter logic [31:0] DATA_KEY    = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    output logic        ddr_ready
);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_BURST = 2'd3;

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [IW-1:0] INIT_TC  = IW'(INIT_CYCLES - 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    logic [1:0]    state;
    logic [IW-1:0] init_cnt;
    logic [LW-1:0] lat_cnt;
    logic [31:0]   beat_addr;
    logic [7:0]    beat_cnt;
    logic [7:0]    len;
    logic [31:0]   aligned_addr;
    logic [31:0]   next_addr;
    logic [7:0]    next_cnt;

    assign aligned_addr = araddr & 32'hFFFF_FFFC;
    assign next_addr    = beat_addr + 32'd4;
    assign next_cnt     = beat_cnt + 8'd1;

    function automatic logic [1:0] beat_resp(input logic [31:0] a);
        return (a >= ADDR_LIMIT) ? 2'b10 : 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            lat_cnt   <= '0;
            beat_addr <= '0;
            beat_cnt  <= '0;
            len       <= '0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rresp     <= 2'b00;
            rdata     <= '0;
            ddr_ready <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_cnt == INIT_TC) begin
                        init_cnt  <= '0;
                        ddr_ready <= 1'b1;
                        arready   <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (arvalid) begin
                        arready   <= 1'b0;
                        len       <= arlen;
                        beat_cnt  <= '0;
                        beat_addr <= aligned_addr;
                        if (RD_LATENCY == 0) begin
                            rvalid <= 1'b1;
                            rdata  <= aligned_addr ^ DATA_KEY;
                            rresp  <= beat_resp(aligned_addr);
                            rlast  <= (arlen == 8'd0);
                            state  <= S_BURST;
                        end else begin
                            lat_cnt <= LAT_LOAD;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        rvalid <= 1'b1;
                        rdata  <= beat_addr ^ DATA_KEY;
                        rresp  <= beat_resp(beat_addr);
                        rlast  <= (len == 8'd0);
                        state  <= S_BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_BURST: begin
                    // Outputs only move on a handshake, so a stalled beat stays put.
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            beat_addr <= next_addr;
                            beat_cnt  <= next_cnt;
                            rdata     <= next_addr ^ DATA_KEY;
                            rresp     <= beat_resp(next_addr);
                            rlast     <= (next_cnt == len);
                        end
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: doc/ddr_ctr_rd_resp.md
DDR_CTR_RD_RESP -- requirements
Module: ddr_ctr_rd_resp

Interface
REQ-001 Parameter INIT_CYCLES, default 16: cycles after reset before ddr_ready asserts; minimum 1.
REQ-002 Parameter RD_LATENCY, default 4: idle cycles between the AR handshake cycle and the first rvalid cycle; minimum 0.
REQ-003 Parameter ADDR_LIMIT, default 32'h0001_0000: beat addresses >= this value return SLVERR.
REQ-004 Parameter DATA_KEY, default 32'hA5A5_0000: XOR key for the generated read data.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 araddr  input  32  read burst start address (byte address).
REQ-009 arlen  input  8  burst length minus one (INCR, 4-byte beats).
REQ-010 arvalid  input  1  read address valid from the initiator.
REQ-011 arready  output  1  responder accepts the read address.
REQ-012 rdata  output  32  read data beat.
REQ-013 rresp  output  2  2'b00 OKAY, 2'b10 SLVERR, per beat.
REQ-014 rlast  output  1  final beat of the burst.
REQ-015 rvalid  output  1  read data valid.
REQ-016 rready  input  1  initiator accepts the read data.
REQ-017 ddr_ready  output  1  memory model initialised; initiator may begin issuing requests.

Function
REQ-018 States: INIT, IDLE, WAIT, BURST; all outputs registered.
REQ-019 INIT: counter counts INIT_CYCLES cycles, then ddr_ready<=1 and state<=IDLE; ddr_ready then stays 1 until rst.
REQ-020 IDLE: arready=1; AR handshake (arvalid & arready) captures {araddr[31:2],2'b00} and arlen, drops arready next cycle, enters WAIT (or BURST directly when RD_LATENCY=0).
REQ-021 arready is 0 in INIT, WAIT and BURST; only one burst is outstanding at a time; arvalid in those states is ignored and stays pending.
REQ-022 WAIT: down-counter runs RD_LATENCY cycles with rvalid=0, then BURST with rvalid=1 for beat 0.
REQ-023 BURST: rvalid, rdata, rresp and rlast hold stable while rvalid & ~rready.
REQ-024 Beat data: rdata = beat_addr ^ DATA_KEY; rresp = 2'b10 if beat_addr >= ADDR_LIMIT, else 2'b00.
REQ-025 On each R handshake, beat_addr += 4 (modulo 2^32, wraps silently) and the beat counter increments; the next beat presents in the following cycle with no bubble.
REQ-026 rlast = 1 exactly when beat counter == captured arlen; arlen=255 yields 256 beats.
REQ-027 R handshake with rlast: rvalid<=0, state<=IDLE, arready<=1 on the same edge, so a new AR is accepted no earlier than the cycle after the last beat.
REQ-028 rready may be asserted before rvalid; a beat transfers only when rvalid & rready are both high.

Reset
REQ-029 rst=1 at any edge: state<=INIT, arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, ddr_ready=0, and all counters cleared.
REQ-030 rst mid-burst abandons the burst without completing it; the INIT delay reruns before ddr_ready reasserts.

Verification
REQ-031 Reset release with defaults -> ddr_ready rises exactly 16 cycles later; arready=1 from the same cycle.
REQ-032 AR addr 0x100, len 0, rready held 1 -> exactly 4 idle cycles, then 1 beat: rdata 0xA5A5_0100, rresp 00, rlast 1; arready returns the next cycle.
REQ-033 AR addr 0x0, len 3, rready toggled 1/0 -> 4 beats 0xA5A5_0000..0xA5A5_000C, each held stable while stalled, rlast only on beat 3.
REQ-034 AR addr 0xFFF8, len 3 -> rresp 00,00,10,10 (addresses 0xFFF8, 0xFFFC, 0x10000, 0x10004).
REQ-035 AR addr 0xFFFF_FFFC, len 1 -> second beat address wraps to 0x0, giving rdata 0xA5A5_0000; arvalid held high during the burst is not accepted until after rlast.
REQ-036 rst pulsed during beat 2 of 8 -> next cycle rvalid=0 and ddr_ready=0; INIT reruns; a fresh burst afterwards completes correctly.
